mtsp_bus_rdata_packer: RTL
==========================

MTSP_BUS_RDATA_PACKER -- requirements
Module: mtsp_bus_rdata_packer

Interface
- REQ-001 The block SHALL take parameter BEAT_W, default 64: bus read beat width in bits; only 64 is legal.
- REQ-002 The block SHALL take parameter LEN_W, default 9: width of the command length field.
- REQ-003 The block SHALL have port CLK  input  1  main clock; all state changes on its rising edge.
- REQ-004 The block SHALL have port nRST  input  1  asynchronous, active-low reset.
- REQ-005 The block SHALL have port CMD_VALID  input  1  read command present.
- REQ-006 The block SHALL have port CMD_SIZE  input  LEN_W  number of 256-bit words to receive.
- REQ-007 The block SHALL have port CMD_READY  output  1  command accepted when high with CMD_VALID.
- REQ-008 The block SHALL have port RVALID  input  BEAT_W/64  bus read beat valid.
- REQ-009 The block SHALL have port RDATA  input  BEAT_W  bus read beat data.
- REQ-010 The block SHALL have port RREADY  output  1  beat accepted when high with RVALID.
- REQ-011 The block SHALL have port MEM_OE  output  1  one-cycle pulse marking MEM_ODATA valid.
- REQ-012 The block SHALL have port MEM_ODATA  output  256  packed DWORDx8 word.
- REQ-013 The block SHALL have port BUSY  output  1  command in progress.
- REQ-014 The block SHALL have port ERR  output  1  sticky protocol error flag.

Function
- REQ-015 The block SHALL implement states IDLE and RECV; BUSY SHALL be high exactly when the state is RECV.
- REQ-016 CMD_READY SHALL be high exactly in IDLE; a CMD_VALID&CMD_READY handshake SHALL load the word counter with CMD_SIZE, clear the beat index, and enter RECV next cycle.
- REQ-017 A handshake with CMD_SIZE=0 SHALL be a no-op: the state remains IDLE and no beat is accepted.
- REQ-018 RREADY SHALL be high exactly in RECV; CMD_VALID in RECV SHALL be ignored.
- REQ-019 The accepted beat k (k=0..3) of each word SHALL be written to MEM_ODATA bits [64k+63:64k], so the first beat fills the lowest lane.
- REQ-020 The 2-bit beat index SHALL advance on each accepted beat and wrap from 3 to 0; the wrap SHALL decrement the word counter.
- REQ-021 MEM_OE SHALL pulse high for exactly one cycle, the cycle after the 4th beat of a word is accepted; MEM_ODATA SHALL then hold that word until the next word completes.
- REQ-022 Acceptance of the 4th beat with the word counter at 1 SHALL return the state to IDLE next cycle, so MEM_OE is high and BUSY is low in the same cycle.
- REQ-023 A new command SHALL be accepted in the cycle the final MEM_OE is high, with no bubble.
- REQ-024 Cycles with RVALID low in RECV SHALL hold all state; there is no timeout.
- REQ-025 MEM_ODATA lanes not yet rewritten for the current word SHALL retain the previous word's data, because only complete words are flagged.

Reset
- REQ-026 While nRST is low, the block SHALL drive state=IDLE, BUSY=0, CMD_READY=1 (combinational from IDLE), RREADY=0, MEM_OE=0, MEM_ODATA=0, ERR=0, word counter=0, and beat index=0.
- REQ-027 Reset mid-command SHALL discard any partial word without a MEM_OE pulse; beats arriving after reset release SHALL be treated as IDLE traffic.

Configuration
- REQ-028 With macro MTSP_RDATA_OVERRUN_CHECK_EN defined, RVALID high in IDLE SHALL set ERR on the next edge, and ERR SHALL stay set until reset; the beat is dropped either way.
- REQ-029 Without MTSP_RDATA_OVERRUN_CHECK_EN, ERR SHALL be constant 0 and no check logic SHALL be built.

Verification
- REQ-030 Scenario: command CMD_SIZE=1, then beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles -> MEM_OE pulses once, MEM_ODATA=0x44..44_33..33_22..22_11..11, and BUSY falls in the MEM_OE cycle.
- REQ-031 Scenario: CMD_SIZE=3 with RVALID toggling every other cycle -> exactly 3 MEM_OE pulses, each 1 cycle after every 4th accepted beat.
- REQ-032 Scenario: CMD_SIZE=0 -> CMD_READY stays high, BUSY stays 0, RREADY stays 0, and no MEM_OE.
- REQ-033 Scenario: nRST pulled low after 2 beats of CMD_SIZE=2 -> all outputs at reset values, no MEM_OE, and the next command CMD_SIZE=1 packs correctly from lane 0.
- REQ-034 Scenario: back-to-back commands with CMD_VALID held high and CMD_SIZE=1 -> the second command is accepted in the first command's MEM_OE cycle.
- REQ-035 Scenario: RVALID=1 in IDLE -> ERR=1 next cycle and held when MTSP_RDATA_OVERRUN_CHECK_EN is defined; ERR=0 otherwise; no MEM_OE in either build.

Source files
------------

// File: rtl/mtsp_bus_rdata_packer.sv
// Packs four 64-bit bus read beats into one 256-bit DWORDx8 word and flags each complete word.
// Optional macro MTSP_RDATA_OVERRUN_CHECK_EN builds a sticky error for beats arriving while idle.
module mtsp_bus_rdata_packer #(
  parameter int BEAT_W = 64,
  parameter int LEN_W  = 9
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  CMD_VALID,
  input  logic [LEN_W-1:0]      CMD_SIZE,
  output logic                  CMD_READY,
  input  logic [BEAT_W/64-1:0]  RVALID,
  input  logic [BEAT_W-1:0]     RDATA,
  output logic                  RREADY,
  output logic                  MEM_OE,
  output logic [255:0]          MEM_ODATA,
  output logic                  BUSY,
  output logic                  ERR
);

  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [LEN_W-1:0]   word_cnt;
  logic [1:0]         beat_idx;
  logic [255:0]       odata;
  logic               oe;
  logic               cmd_fire;
  logic               beat_fire;
  logic               word_done;
  logic               last_word;

  // A zero-length command is a no-op, so it never counts as a handshake.
  assign cmd_fire  = (state == IDLE) && CMD_VALID && (CMD_SIZE != {LEN_W{1'b0}});
  assign beat_fire = (state == RECV) && RVALID[0];
  assign word_done = beat_fire && (beat_idx == 2'd3);
  assign last_word = word_done && (word_cnt == {{(LEN_W-1){1'b0}}, 1'b1});

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_fire) begin
          state_nxt = RECV;
        end else begin
          state_nxt = IDLE;
        end
      end
      RECV: begin
        if (last_word) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = RECV;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Lanes are written in place; only whole words are announced through MEM_OE.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      word_cnt <= {LEN_W{1'b0}};
      beat_idx <= 2'd0;
      odata    <= 256'd0;
      oe       <= 1'b0;
    end else begin
      oe <= word_done;
      if (cmd_fire) begin
        word_cnt <= CMD_SIZE;
        beat_idx <= 2'd0;
      end else if (beat_fire) begin
        odata[{beat_idx, 6'b000000} +: 64] <= RDATA[63:0];
        beat_idx <= beat_idx + 2'd1;
        if (word_done) begin
          word_cnt <= word_cnt - {{(LEN_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign CMD_READY = (state == IDLE);
  assign RREADY    = (state == RECV);
  assign BUSY      = (state == RECV);
  assign MEM_OE    = oe;
  assign MEM_ODATA = odata;

`ifdef MTSP_RDATA_OVERRUN_CHECK_EN
  logic err;

  // Sticky flag for read beats that show up with no command in progress.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      err <= 1'b0;
    end else if ((state == IDLE) && RVALID[0]) begin
      err <= 1'b1;
    end
  end

  assign ERR = err;
`else
  assign ERR = 1'b0;
`endif

endmodule
